// File: rtl/col_idct_8pt.sv
// Single-column 8-point inverse DCT (Chen-Wang, nanojpeg constants) with level shift and clipping.
// Output register loads f(col_idct_ip) every cycle: 8 pixel words plus a shortcut status word.
module col_idct_8pt (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] col_idct_ip,
    output logic [287:0] col_idct_op
);

    typedef logic signed [31:0] s32_t;

    localparam s32_t W1   = 32'sd2841;
    localparam s32_t W2   = 32'sd2676;
    localparam s32_t W3   = 32'sd2408;
    localparam s32_t W5   = 32'sd1609;
    localparam s32_t W6   = 32'sd1108;
    localparam s32_t W7   = 32'sd565;
    localparam s32_t C181 = 32'sd181;

    function automatic logic [31:0] clip8(input s32_t v);
        if (v < 0)
            return 32'd0;
        else if (v > 255)
            return 32'd255;
        else
            return {24'd0, v[7:0]};
    endfunction

    function automatic logic [31:0] pix(input s32_t v);
        return clip8((v >>> 14) + 32'sd128);
    endfunction

    s32_t         in_w [8];
    s32_t         x0, x1, x2, x3, x4, x5, x6, x7, x8, x0b;
    s32_t         t1, t2, t3;
    s32_t         a, b, c, d, e, g, h, m, r, s;
    logic [31:0]  px [8];
    logic [31:0]  dc;
    logic         shortcut;
    logic [287:0] next_op;

    always_comb begin
        for (int unsigned k = 0; k < 8; k++)
            in_w[k] = s32_t'(col_idct_ip[32*k +: 32]);

        shortcut = (col_idct_ip[255:32] == '0);
        dc       = clip8(((in_w[0] + 32'sd32) >>> 6) + 32'sd128);

        // Full path is always evaluated so every intermediate is assigned each pass.
        x1  = in_w[4] <<< 8;
        x0  = (in_w[0] <<< 8) + 32'sd8192;

        t1  = W7 * (in_w[1] + in_w[7]) + 32'sd4;
        x4  = (t1 + (W1 - W7) * in_w[1]) >>> 3;
        x5  = (t1 - (W1 + W7) * in_w[7]) >>> 3;

        t2  = W3 * (in_w[5] + in_w[3]) + 32'sd4;
        x6  = (t2 - (W3 - W5) * in_w[5]) >>> 3;
        x7  = (t2 - (W3 + W5) * in_w[3]) >>> 3;

        x8  = x0 + x1;
        x0b = x0 - x1;

        t3  = W6 * (in_w[2] + in_w[6]) + 32'sd4;
        x2  = (t3 - (W2 + W6) * in_w[6]) >>> 3;
        x3  = (t3 + (W2 - W6) * in_w[2]) >>> 3;

        a = x4 + x6;
        b = x4 - x6;
        c = x5 + x7;
        d = x5 - x7;
        e = x8 + x3;
        g = x8 - x3;
        h = x0b + x2;
        m = x0b - x2;

        r = (C181 * (b + d) + 32'sd128) >>> 8;
        s = (C181 * (b - d) + 32'sd128) >>> 8;

        px[0] = pix(e + a);
        px[1] = pix(h + r);
        px[2] = pix(m + s);
        px[3] = pix(g + c);
        px[4] = pix(g - c);
        px[5] = pix(m - s);
        px[6] = pix(h - r);
        px[7] = pix(e - a);

        next_op = '0;
        for (int unsigned k = 0; k < 8; k++)
            next_op[32*k +: 32] = shortcut ? dc : px[k];
        next_op[256] = shortcut;
    end

    always_ff @(posedge clk) begin
        if (reset)
            col_idct_op <= '0;
        else
            col_idct_op <= next_op;
    end

endmodule

// File: tb/tb_col_idct_8pt.sv
// Self-checking bench for col_idct_8pt: hand-computed vector table, reset and
// back-to-back random sequences checked against an integer reference model.
module tb_col_idct_8pt;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] ip;
    logic [287:0] op;

    always #5 clk = ~clk;

    col_idct_8pt dut (
        .clk        (clk),
        .reset      (reset),
        .col_idct_ip(ip),
        .col_idct_op(op)
    );

    typedef struct {
        string        name;
        logic [255:0] ip;
        logic [287:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    function automatic logic [255:0] mkip(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [287:0] mkexp(input int p0, p1, p2, p3, p4, p5, p6, p7,
                                           input int st);
        logic [287:0] r;
        int           p[8];
        p = '{p0, p1, p2, p3, p4, p5, p6, p7};
        r = '0;
        for (int k = 0; k < 8; k++) r[32*k +: 8] = p[k][7:0];
        r[256] = st[0];
        return r;
    endfunction

    function automatic logic [287:0] flat(input int p, input int st);
        return mkexp(p, p, p, p, p, p, p, p, st);
    endfunction

    function automatic logic [7:0] clipi(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Integer reference: int arithmetic wraps at 32 bits and >>> is arithmetic.
    function automatic logic [287:0] model(input logic [255:0] x);
        int v[8];
        int y0, y1, y2, y3, y4, y5, y6, y7, y8, t;
        int u[4], w[4];
        logic [287:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) v[k] = int'(x[32*k +: 32]);
        if (x[255:32] == 0) begin
            for (int k = 0; k < 8; k++) r[32*k +: 8] = clipi(((v[0] + 32) >>> 6) + 128);
            r[256] = 1'b1;
            return r;
        end
        y0 = (v[0] << 8) + 8192;
        y1 = v[4] << 8;
        y2 = v[6]; y3 = v[2]; y4 = v[1]; y5 = v[7]; y6 = v[5]; y7 = v[3];
        t  = 565 * (y4 + y5) + 4;
        y4 = (t + 2276 * y4) >>> 3;
        y5 = (t - 3406 * y5) >>> 3;
        t  = 2408 * (y6 + y7) + 4;
        y6 = (t - 799 * y6) >>> 3;
        y7 = (t - 4017 * y7) >>> 3;
        y8 = y0 + y1;
        y0 = y0 - y1;
        t  = 1108 * (y3 + y2) + 4;
        y2 = (t - 3784 * y2) >>> 3;
        y3 = (t + 1568 * y3) >>> 3;
        u = '{y8 + y3, y0 + y2, y0 - y2, y8 - y3};
        w = '{y4 + y6,
              (181 * ((y4 - y6) + (y5 - y7)) + 128) >>> 8,
              (181 * ((y4 - y6) - (y5 - y7)) + 128) >>> 8,
              y5 + y7};
        for (int k = 0; k < 4; k++) begin
            r[32*k +: 8]       = clipi(((u[k] + w[k]) >>> 14) + 128);
            r[32*(7-k) +: 8]   = clipi(((u[k] - w[k]) >>> 14) + 128);
        end
        return r;
    endfunction

    function automatic logic [255:0] rnd_ip();
        logic [255:0] r;
        int           v;
        logic         dc_only;
        dc_only = ($urandom_range(15) == 0);
        for (int k = 0; k < 8; k++) begin
            v = int'($urandom_range(4096)) - 2048;
            if (k > 0 && (dc_only || $urandom_range(3) == 0)) v = 0;
            r[32*k +: 32] = v;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [287:0] exp);
        applied++;
        if (op !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, op, exp);
        end
    endtask

    task automatic apply(input string name, input logic [255:0] v, input logic [287:0] exp);
        @(negedge clk);
        ip = v;
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    logic [255:0] cur;
    logic         rst_cur;

    initial begin
        vecs.push_back('{"all_zero",  mkip(0, 0, 0, 0, 0, 0, 0, 0),      flat(128, 1)});
        vecs.push_back('{"dc_640",    mkip(640, 0, 0, 0, 0, 0, 0, 0),    flat(138, 1)});
        vecs.push_back('{"dc_sat_hi", mkip(20000, 0, 0, 0, 0, 0, 0, 0),  flat(255, 1)});
        vecs.push_back('{"dc_sat_lo", mkip(-20000, 0, 0, 0, 0, 0, 0, 0), flat(0, 1)});
        vecs.push_back('{"dc_m32",    mkip(-32, 0, 0, 0, 0, 0, 0, 0),    flat(128, 1)});
        vecs.push_back('{"dc_m33",    mkip(-33, 0, 0, 0, 0, 0, 0, 0),    flat(127, 1)});
        vecs.push_back('{"dc_8095",   mkip(8095, 0, 0, 0, 0, 0, 0, 0),   flat(254, 1)});
        vecs.push_back('{"dc_8096",   mkip(8096, 0, 0, 0, 0, 0, 0, 0),   flat(255, 1)});
        vecs.push_back('{"dc_wrap",   mkip(2147483647, 0, 0, 0, 0, 0, 0, 0), flat(0, 1)});
        vecs.push_back('{"ac4_64",    mkip(0, 0, 0, 0, 64, 0, 0, 0),
                         mkexp(129, 127, 127, 129, 129, 127, 127, 129, 0)});
        vecs.push_back('{"ac1_neg",   mkip(0, -1, 0, 0, 0, 0, 0, 0),     flat(128, 0)});
        vecs.push_back('{"ac7_pos",   mkip(0, 0, 0, 0, 0, 0, 0, 1),      flat(128, 0)});

        // Reset with random inputs held, then release.
        reset = 1'b1;
        ip    = rnd_ip();
        @(posedge clk); #1;
        check("reset", '0);
        ip = rnd_ip();
        @(posedge clk); #1;
        check("reset_hold", '0);
        cur   = rnd_ip();
        ip    = cur;
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_release", model(cur));

        foreach (vecs[i]) apply(vecs[i].name, vecs[i].ip, vecs[i].exp);

        // Full-path extremes: every word at the positive/negative limit.
        cur = {8{32'h7FFFFFFF}};
        apply("ext_max", cur, model(cur));
        if ($isunknown(op)) begin
            miscompares++;
            $display("FAIL ext_max_x got=%h exp=no_x", op);
        end
        cur = {8{32'h80000000}};
        apply("ext_min", cur, model(cur));
        cur = mkip(1000, -700, 300, 2047, -2048, 5, -9, 640);
        apply("mixed", cur, model(cur));

        // Back-to-back stream, one new vector per cycle, reset pulsed mid-stream.
        @(negedge clk);
        cur     = rnd_ip();
        rst_cur = 1'b0;
        ip      = cur;
        reset   = rst_cur;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_%0d", i), rst_cur ? '0 : model(cur));
            cur     = rnd_ip();
            rst_cur = (i == 5000);
            ip      = cur;
            reset   = rst_cur;
        end
        @(posedge clk); #1;
        check("b2b_tail", model(cur));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
